icache_rd_responder: RTL and testbench
======================================

# icache_rd_responder

Read-only, direct-mapped instruction-cache responder serving the fetch stage's memory request interface. It accepts word reads on `Addr`/`Rd` and answers with `DataOut`/`Done`/`Stall`/`CacheHit`/`valid`/`err`. On a miss it fills a 4-word line from a backing memory through a request/acknowledge port. It replaces the fetch-side memory system; the fetch stage is the initiator and this block is the responder.

## Interface
- `LINES`, 8: number of cache lines; power of two, at least 2. IDX = log2(LINES). Tag width TW = 13 − IDX (10 at the default).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `Addr` input 16: byte address of the requested instruction word.
- `Rd` input 1: read request; level-sensitive, sampled every cycle in IDLE.
- `Wr` input 1: write request; unsupported, causes an error response.
- `inv` input 1: invalidate all lines.
- `mem_rdata` input 16: backing-memory read data, valid while `mem_ack` = 1.
- `mem_ack` input 1: backing memory has completed the current word read.
- `DataOut` output 16: instruction word.
- `Done` output 1: one-cycle response strobe.
- `Stall` output 1: request accepted; a miss is in progress.
- `CacheHit` output 1: the response came from a hit.
- `valid` output 1: `DataOut` holds a real instruction this cycle.
- `err` output 1: error response.
- `mem_addr` output 16: backing-memory word address.
- `mem_rd` output 1: backing-memory read request.

## Operation
- Address fields:
  - offset = `Addr[2:1]`
  - index = `Addr[IDX+2:3]`
  - tag = `Addr[15:IDX+3]`
  - `Addr[0]` must be 0.
- Storage: per line, one valid bit, a TW-bit tag and 4×16-bit data words.
- States: IDLE, FILL, RESP.
- IDLE, `Rd`=0: all outputs 0; no state change except `inv`.
- IDLE, `Rd`=1 and (`Wr`=1 or `Addr[0]`=1): `Done`=`err`=1, `DataOut`=0, `valid`=0; stay in IDLE.
- IDLE, `Rd`=1, hit (line valid and tag equal): combinational response in the same cycle with `Done`=`CacheHit`=`valid`=1 and `DataOut` = the addressed word; stay in IDLE.
- IDLE, `Rd`=1, miss:
  - `Stall`=1 and `Done`=0 in the same cycle.
  - Latch `Addr[15:1]`; clear word counter `cnt`; go to FILL.
- FILL:
  - `Stall`=1; `mem_rd`=1; `mem_addr` = {latched tag, latched index, `cnt`, 1'b0}.
  - On `mem_ack`: write `mem_rdata` into word `cnt`.
  - If `cnt`=3: write the tag, set the line's valid bit, go to RESP. Otherwise increment `cnt`; `mem_rd` stays high with the new address in the next cycle.
- RESP (one cycle): `Done`=`valid`=1, `CacheHit`=0, `Stall`=0, `DataOut` = the latched-offset word of the new line. Go to IDLE. Inputs are ignored in RESP.
- `Addr`, `Rd` and `Wr` are ignored in FILL and RESP. The fill always completes for the latched address, even if fetch redirects `Addr` mid-miss.
- After RESP, an `Rd` still held on the same address hits in IDLE and produces a second response; fetch discards it.
- `inv`:
  - In IDLE: all valid bits clear at the edge. A lookup in that same cycle uses the pre-invalidate state.
  - In FILL or RESP: sets a pending flag; the clear is applied on the first IDLE cycle, including the line just filled.
- `mem_ack` outside FILL is ignored.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = IDLE, all valid bits = 0, pending `inv` = 0, `cnt` = 0.
  - `mem_rd`=0, `mem_addr`=0, and `Done`/`Stall`/`CacheHit`/`valid`/`err`/`DataOut` all 0.
- Reset asserted mid-fill aborts the fill; the partial line stays invalid.
- Hit latency: 0 cycles (response in the request cycle).
- Miss latency, with memory acking on the N-th cycle of each word request (N ≥ 1):
  - Miss detected in cycle 0.
  - Word k is acked in cycle (k+1)·N.
  - RESP (`Done`) in cycle 4N+1.
  - `Stall` is high in cycles 0 through 4N.
- `mem_rd` is never high outside FILL. `mem_addr` changes only on the cycle after an ack.
- `Done` and `Stall` are never high together. `CacheHit`=1 implies `Done`=1.

## Test plan
- Reset, then `Rd`=1 at `Addr`=0x0000 with a memory returning 0x1000+word number and N=1 -> `Stall` in cycles 0–4, `mem_addr` steps 0,2,4,6, `Done`=1/`CacheHit`=0/`DataOut`=0x1000 in cycle 5, then a hit with `DataOut`=0x1000 in cycle 6.
- After filling line 0, `Rd` at 0x0006 -> same-cycle `Done`=`CacheHit`=1, `DataOut`=0x1003. `Rd` at 0x0046 (same index, different tag) -> miss, refill, line now tagged 1.
- Miss at 0x0010 with N=3, `Addr` switched to 0x0000 in cycle 2 -> `mem_addr` stays 0x0010–0x0016, RESP in cycle 13 with word 0x0010's data.
- `Rd` with `Addr`=0x0003, then `Rd`+`Wr` at 0x0004 -> each gives same-cycle `Done`=`err`=1, `valid`=0, `mem_rd` never asserted.
- `inv` pulsed during a fill at 0x0020 -> RESP still delivers data; the following `Rd` at 0x0020 misses again. `inv` in IDLE together with a hitting `Rd` -> that cycle hits, the next cycle misses.
- `rst_n` dropped in FILL after 2 acks -> `mem_rd` falls immediately; after release, `Rd` at the same address misses.

Source files
------------

// File: rtl/icache_rd_responder.sv
// Direct-mapped, read-only instruction cache responder: same-cycle hits,
// 4-word line fill from a req/ack backing memory on a miss.
module icache_rd_responder #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        inv,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        valid,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 13 - IDX;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] vld_q, vld_d;
  logic [15:1]      addr_q, addr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             inv_pend_q, inv_pend_d;
  logic             fill_we;

  logic [TW-1:0] tag_mem_q  [LINES];
  logic [15:0]   data_mem_q [LINES][4];

  logic [IDX-1:0] req_idx, fill_idx;
  logic [TW-1:0]  req_tag, fill_tag;
  logic [1:0]     req_off, fill_off;
  logic           hit, bad_req;

  assign req_idx  = Addr[IDX+2:3];
  assign req_tag  = Addr[15:IDX+3];
  assign req_off  = Addr[2:1];
  assign fill_idx = addr_q[IDX+2:3];
  assign fill_tag = addr_q[15:IDX+3];
  assign fill_off = addr_q[2:1];

  assign hit     = vld_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
  assign bad_req = Wr | Addr[0];

  // Address is a pure function of the latched line and word counter, so it
  // only moves when cnt advances on an ack (or a new miss is latched).
  assign mem_addr = {addr_q[15:3], cnt_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    fill_we    = 1'b0;
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    valid      = 1'b0;
    err        = 1'b0;
    mem_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear lands at the edge; this cycle's lookup still sees old valids.
        if (inv || inv_pend_q) begin
          vld_d      = '0;
          inv_pend_d = 1'b0;
        end
        if (Rd) begin
          if (bad_req) begin
            Done = 1'b1;
            err  = 1'b1;
          end else if (hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            valid    = 1'b1;
            DataOut  = data_mem_q[req_idx][req_off];
          end else begin
            Stall   = 1'b1;
            addr_d  = Addr[15:1];
            cnt_d   = 2'd0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        Stall  = 1'b1;
        mem_rd = 1'b1;
        if (inv) inv_pend_d = 1'b1;
        if (mem_ack) begin
          fill_we = 1'b1;
          if (cnt_q == 2'd3) begin
            vld_d[fill_idx] = 1'b1;
            state_d         = RESP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      RESP: begin
        Done    = 1'b1;
        valid   = 1'b1;
        DataOut = data_mem_q[fill_idx][fill_off];
        if (inv) inv_pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  // Tag/data storage needs no reset: every use is gated by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem_q[fill_idx][cnt_q] <= mem_rdata;
      if (cnt_q == 2'd3) tag_mem_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_rd_responder.sv
// Directed bench for icache_rd_responder with a scoreboard of expected
// responses and a backing memory that acks on the N-th cycle of each word.
module tb_icache_rd_responder;
  logic        clk, rst_n;
  logic [15:0] Addr;
  logic        Rd, Wr, inv;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, valid, err;
  logic [15:0] mem_addr;
  logic        mem_rd;

  icache_rd_responder #(.LINES(8)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .Rd(Rd), .Wr(Wr), .inv(inv),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .DataOut(DataOut), .Done(Done),
    .Stall(Stall), .CacheHit(CacheHit), .valid(valid), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        hit;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   memN  = 1;

  // Backing memory: word at byte address a holds 0x1000 + a/2.
  initial begin
    int k;
    k = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_rd) begin
        k++;
        if (k == memN) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'h1000 + {1'b0, mem_addr[15:1]};
          k = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        k = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    exp_t e;
    @(negedge clk);
    chk("done_stall_excl", {31'd0, Done & Stall}, 0);
    chk("hit_implies_done", {31'd0, CacheHit & ~Done}, 0);
    if (Done) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_mis++;
        $error("FAIL unexpected_done: observed Done=1 expected no response");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data",  DataOut,  e.d);
        chk("sb_hit",   CacheHit, e.hit);
        chk("sb_err",   err,      e.er);
        chk("sb_valid", valid,    !e.er);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_hit(input logic [15:0] a, input logic [15:0] exp_w);
    Rd = 1'b1; Addr = a;
    sb.push_back('{d: exp_w, hit: 1'b1, er: 1'b0});
    smp();
    chk("hit_done", Done, 1);
    chk("hit_stall", Stall, 0);
    cyc();
    Rd = 1'b0;
  endtask

  task automatic do_err(input logic [15:0] a, input logic wr);
    Rd = 1'b1; Wr = wr; Addr = a;
    sb.push_back('{d: 16'h0000, hit: 1'b0, er: 1'b1});
    smp();
    chk("err_done", Done, 1);
    chk("err_memrd", mem_rd, 0);
    chk("err_stall", Stall, 0);
    cyc();
    Rd = 1'b0; Wr = 1'b0;
    smp();
    chk("err_idle_memrd", mem_rd, 0);
    cyc();
  endtask

  task automatic do_miss(input logic [15:0] a, input int n, input logic [15:0] exp_w,
                         input bit hold, input int redir_c, input logic [15:0] redir_a,
                         input int inv_c);
    logic [1:0] w;
    memN = n;
    Rd = 1'b1; Addr = a;
    sb.push_back('{d: exp_w, hit: 1'b0, er: 1'b0});
    smp();
    chk("miss_stall0", Stall, 1);
    chk("miss_done0", Done, 0);
    chk("miss_memrd0", mem_rd, 0);
    cyc();
    if (!hold) Rd = 1'b0;
    for (int c = 1; c <= 4 * n; c++) begin
      if (c == redir_c) Addr = redir_a;
      inv = (c == inv_c);
      w = 2'((c - 1) / n);
      smp();
      chk("fill_stall", Stall, 1);
      chk("fill_memrd", mem_rd, 1);
      chk("fill_memaddr", mem_addr, {a[15:3], w, 1'b0});
      cyc();
    end
    inv = 1'b0;
    smp();
    chk("resp_done", Done, 1);
    chk("resp_stall", Stall, 0);
    chk("resp_memrd", mem_rd, 0);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; inv = 1'b0; Addr = '0;
    smp();
    chk("rst_memrd", mem_rd, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_done", Done, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_dataout", DataOut, 0);
    chk("rst_err", err, 0);
    cyc();
    rst_n = 1'b1;
    Addr = 16'h0042;
    smp();
    chk("idle_norq_done", Done, 0);
    chk("idle_norq_stall", Stall, 0);
    chk("idle_norq_valid", valid, 0);
    cyc();

    // Cold miss at 0, N=1, Rd held: RESP in cycle 5 then a hit in cycle 6.
    do_miss(16'h0000, 1, 16'h1000, 1'b1, 0, 16'h0000, 0);
    do_hit(16'h0000, 16'h1000);
    do_hit(16'h0006, 16'h1003);
    // Same index, different tag: refill, then old tag misses.
    do_miss(16'h0046, 1, 16'h1023, 1'b0, 0, 16'h0000, 0);
    do_hit(16'h0046, 16'h1023);
    do_miss(16'h0000, 1, 16'h1000, 1'b0, 0, 16'h0000, 0);

    // N=3 with Addr redirected mid-miss.
    do_miss(16'h0010, 3, 16'h1008, 1'b0, 2, 16'h0000, 0);
    do_hit(16'h0012, 16'h1009);

    do_err(16'h0003, 1'b0);
    do_err(16'h0004, 1'b1);

    // inv during a fill: data still delivered, line gone afterwards.
    do_miss(16'h0020, 2, 16'h1010, 1'b0, 0, 16'h0000, 3);
    smp();
    chk("idle_gap_done", Done, 0);
    cyc();
    do_miss(16'h0020, 2, 16'h1010, 1'b0, 0, 16'h0000, 0);

    // inv in IDLE with a hitting Rd: hit now, miss next cycle.
    Rd = 1'b1; Addr = 16'h0020; inv = 1'b1;
    sb.push_back('{d: 16'h1010, hit: 1'b1, er: 1'b0});
    smp();
    chk("inv_hit_done", Done, 1);
    chk("inv_hit_cachehit", CacheHit, 1);
    cyc();
    inv = 1'b0;
    do_miss(16'h0020, 1, 16'h1010, 1'b0, 0, 16'h0000, 0);

    // Reset mid-fill after two acks.
    memN = 1;
    Rd = 1'b1; Addr = 16'h0030;
    smp();
    chk("rf_stall0", Stall, 1);
    cyc();
    Rd = 1'b0;
    smp(); chk("rf_ack0_addr", mem_addr, 16'h0030); cyc();
    smp(); chk("rf_ack1_addr", mem_addr, 16'h0032); cyc();
    smp();
    chk("rf_memrd_before", mem_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_memrd_async", mem_rd, 0);
    chk("rf_stall_async", Stall, 0);
    cyc();
    rst_n = 1'b1;
    do_miss(16'h0030, 1, 16'h1018, 1'b0, 0, 16'h0000, 0);
    do_hit(16'h0036, 16'h101B);

    smp();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
